// File: rtl/uart_sort_ctrl.sv
// ---------------------------------------------------------------------------
// uart_sort_ctrl
//
// Frame sequencer sitting between a UART receiver, a bubble-sort engine and a
// UART transmitter.  A frame is a length byte L (1..MAX_LEN) followed by L
// data bytes.  The bytes are collected into an internal buffer, handed to the
// sorter, and the sorted result is streamed back out through the transmitter
// one byte at a time.  Malformed lengths, inter-byte timeouts and bytes that
// arrive while a frame is still being processed are reported on o_Err.
//
// Ports
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_byte       receiver byte-valid pulse and byte
//   o_Sort_start             one-cycle sorter launch pulse
//   o_Sort_len, o_Sort_data  entry count and packed buffer (entry k = [8k+7:8k])
//   i_Sort_done, i_Sort_data sorter completion pulse and packed sorted result
//   o_Tx_DV, o_Tx_byte       transmit request pulse and byte (byte is held)
//   i_Tx_active, i_Tx_done   transmitter busy level and per-byte done pulse
//   o_Busy                   high whenever the sequencer is not idle
//   o_Frame_done             one-cycle pulse after the last byte is sent
//   o_Err, o_Err_code        error pulse; code 01 length, 10 timeout,
//                            11 overrun (code holds its last value)
// ---------------------------------------------------------------------------
module uart_sort_ctrl #(
  parameter int MAX_LEN      = 8,
  parameter int TIMEOUT_CLKS = 5700
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_Rx_DV,
  input  logic [7:0]           i_Rx_byte,
  output logic                 o_Sort_start,
  output logic [3:0]           o_Sort_len,
  output logic [8*MAX_LEN-1:0] o_Sort_data,
  input  logic                 i_Sort_done,
  input  logic [8*MAX_LEN-1:0] i_Sort_data,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_byte,
  input  logic                 i_Tx_active,
  input  logic                 i_Tx_done,
  output logic                 o_Busy,
  output logic                 o_Frame_done,
  output logic                 o_Err,
  output logic [1:0]           o_Err_code
);

  typedef enum logic [2:0] {
    IDLE,
    RX_DATA,
    SORT_START,
    SORT_WAIT,
    TX_SEND,
    TX_WAIT,
    DONE
  } state_e;

  localparam logic [1:0]  ERR_LEN     = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;
  localparam logic [1:0]  ERR_OVERRUN = 2'b11;
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);

  state_e      state_q, state_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  tx_idx_q, tx_idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  buf_q [MAX_LEN];
  logic [7:0]  buf_d [MAX_LEN];
  logic        sort_start_q, sort_start_d;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  always_comb begin
    // NOTE: every signal gets its hold/idle value first, so no path through
    // the case statement below can leave one unassigned and infer a latch.
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    tx_idx_d     = tx_idx_q;
    tmo_d        = tmo_q;
    buf_d        = buf_q;
    tx_byte_d    = tx_byte_q;
    err_code_d   = err_code_q;
    tx_dv_d      = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_Rx_DV) begin
          if ((i_Rx_byte != 8'd0) && (i_Rx_byte <= MAX_LEN_B)) begin
            len_d = i_Rx_byte[3:0];
            for (int k = 0; k < MAX_LEN; k++) buf_d[k] = 8'd0;
            idx_d   = 4'd0;
            tmo_d   = 16'd0;
            state_d = RX_DATA;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
          end
        end
      end

      RX_DATA: begin
        // A byte on the very cycle the timeout would fire wins over the
        // timeout, because the byte branch is checked first.
        if (i_Rx_DV) begin
          for (int k = 0; k < MAX_LEN; k++) begin
            if (4'(k) == idx_q) buf_d[k] = i_Rx_byte;
          end
          idx_d = idx_q + 4'd1;
          tmo_d = 16'd0;
          if (idx_q == len_q - 4'd1) state_d = SORT_START;
        end else if (tmo_q == TMO_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          len_d      = 4'd0;
          for (int k = 0; k < MAX_LEN; k++) buf_d[k] = 8'd0;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      SORT_START: state_d = SORT_WAIT;

      SORT_WAIT: begin
        if (i_Sort_done) begin
          // Entries beyond L are forced to zero whatever the sorter returns.
          for (int k = 0; k < MAX_LEN; k++) begin
            buf_d[k] = (4'(k) < len_q) ? i_Sort_data[8*k +: 8] : 8'd0;
          end
          tx_idx_d = 4'd0;
          // Issuing the first byte straight from here keeps the first
          // o_Tx_DV one cycle after i_Sort_done when the transmitter is idle.
          if (!i_Tx_active) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = buf_d[0];
            state_d   = TX_WAIT;
          end else begin
            state_d = TX_SEND;
          end
        end
      end

      TX_SEND: begin
        if (!i_Tx_active) begin
          tx_dv_d = 1'b1;
          for (int k = 0; k < MAX_LEN; k++) begin
            if (4'(k) == tx_idx_q) tx_byte_d = buf_q[k];
          end
          state_d = TX_WAIT;
        end
      end

      TX_WAIT: begin
        if (i_Tx_done) begin
          if (tx_idx_q == len_q - 4'd1) begin
            state_d = DONE;
          end else begin
            tx_idx_d = tx_idx_q + 4'd1;
            state_d  = TX_SEND;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Bytes arriving while a frame is in flight are dropped and flagged;
    // the frame itself carries on untouched.
    if (i_Rx_DV && (state_q inside {SORT_START, SORT_WAIT, TX_SEND, TX_WAIT, DONE})) begin
      err_d      = 1'b1;
      err_code_d = ERR_OVERRUN;
    end

    // Level/pulse outputs registered alongside the state they describe.
    sort_start_d = (state_d == SORT_START);
    frame_done_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      len_q        <= 4'd0;
      idx_q        <= 4'd0;
      tx_idx_q     <= 4'd0;
      tmo_q        <= 16'd0;
      // NOTE: the buffer is visible on o_Sort_data, so unlike a hidden RAM it
      // must be reset to read back as zero.
      for (int k = 0; k < MAX_LEN; k++) buf_q[k] <= 8'd0;
      sort_start_q <= 1'b0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking here would chain registers within one edge.
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      tx_idx_q     <= tx_idx_d;
      tmo_q        <= tmo_d;
      buf_q        <= buf_d;
      sort_start_q <= sort_start_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign o_Sort_start = sort_start_q;
  assign o_Sort_len   = len_q;
  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_byte    = tx_byte_q;
  assign o_Busy       = busy_q;
  assign o_Frame_done = frame_done_q;
  assign o_Err        = err_q;
  assign o_Err_code   = err_code_q;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign o_Sort_data[8*g +: 8] = buf_q[g];
  end

endmodule

// File: tb/tb_uart_sort_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_sort_ctrl
//
// Directed bench for uart_sort_ctrl with default parameters (MAX_LEN=8,
// TIMEOUT_CLKS=5700).  Inputs change on the falling edge; outputs are
// sampled on the falling edge that follows the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_uart_sort_ctrl;

  localparam int MAX_LEN = 8;
  localparam int TMO     = 5700;

  logic                 i_clock;
  logic                 i_reset;
  logic                 i_Rx_DV;
  logic [7:0]           i_Rx_byte;
  logic                 o_Sort_start;
  logic [3:0]           o_Sort_len;
  logic [8*MAX_LEN-1:0] o_Sort_data;
  logic                 i_Sort_done;
  logic [8*MAX_LEN-1:0] i_Sort_data;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_byte;
  logic                 i_Tx_active;
  logic                 i_Tx_done;
  logic                 o_Busy;
  logic                 o_Frame_done;
  logic                 o_Err;
  logic [1:0]           o_Err_code;

  int errors = 0;
  int checks = 0;
  logic seen_dv;

  uart_sort_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_Rx_DV      (i_Rx_DV),
    .i_Rx_byte    (i_Rx_byte),
    .o_Sort_start (o_Sort_start),
    .o_Sort_len   (o_Sort_len),
    .o_Sort_data  (o_Sort_data),
    .i_Sort_done  (i_Sort_done),
    .i_Sort_data  (i_Sort_data),
    .o_Tx_DV      (o_Tx_DV),
    .o_Tx_byte    (o_Tx_byte),
    .i_Tx_active  (i_Tx_active),
    .i_Tx_done    (i_Tx_done),
    .o_Busy       (o_Busy),
    .o_Frame_done (o_Frame_done),
    .o_Err        (o_Err),
    .o_Err_code   (o_Err_code)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_byte = b;
    step();
    i_Rx_DV   = 1'b0;
  endtask

  task automatic sort_done(input logic [63:0] d);
    i_Sort_done = 1'b1;
    i_Sort_data = d;
    step();
    i_Sort_done = 1'b0;
  endtask

  // Transmitter model: busy for three cycles, then done with active dropping.
  task automatic tx_finish();
    i_Tx_active = 1'b1;
    step();
    check("tx_dv_one_cycle", o_Tx_DV, 0);
    step();
    step();
    i_Tx_active = 1'b0;
    i_Tx_done   = 1'b1;
    step();
    i_Tx_done   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sort_start"}, o_Sort_start, 0);
    check({tag, "_tx_dv"},      o_Tx_DV, 0);
    check({tag, "_frame_done"}, o_Frame_done, 0);
    check({tag, "_err"},        o_Err, 0);
    check({tag, "_busy"},       o_Busy, 0);
    check({tag, "_sort_len"},   o_Sort_len, 0);
    check({tag, "_tx_byte"},    o_Tx_byte, 0);
    check({tag, "_err_code"},   o_Err_code, 0);
    check({tag, "_sort_data"},  o_Sort_data, 0);
  endtask

  initial begin
    i_reset     = 1'b1;
    i_Rx_DV     = 1'b0;
    i_Rx_byte   = 8'h00;
    i_Sort_done = 1'b0;
    i_Sort_data = '0;
    i_Tx_active = 1'b0;
    i_Tx_done   = 1'b0;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    i_reset = 1'b0;
    step();
    check("idle_busy", o_Busy, 0);

    // Frame 03,05,01,09 -> sorted 01,05,09
    send_byte(8'h03);
    check("len_busy", o_Busy, 1);
    check("len_no_err", o_Err, 0);
    send_byte(8'h05);
    send_byte(8'h01);
    check("no_early_start", o_Sort_start, 0);
    send_byte(8'h09);
    check("f1_sort_start", o_Sort_start, 1);
    check("f1_sort_len", o_Sort_len, 3);
    check("f1_sort_data", o_Sort_data, 64'h0000_0000_0009_0105);
    step();
    check("f1_sort_start_pulse", o_Sort_start, 0);
    step();
    step();
    check("f1_wait_no_tx", o_Tx_DV, 0);
    sort_done(64'h0000_0000_0009_0501);
    check("f1_tx0_dv", o_Tx_DV, 1);
    check("f1_tx0_byte", o_Tx_byte, 8'h01);
    tx_finish();
    check("f1_tx1_not_yet", o_Tx_DV, 0);
    check("f1_tx_byte_held", o_Tx_byte, 8'h01);
    step();
    check("f1_tx1_dv", o_Tx_DV, 1);
    check("f1_tx1_byte", o_Tx_byte, 8'h05);
    tx_finish();
    step();
    check("f1_tx2_dv", o_Tx_DV, 1);
    check("f1_tx2_byte", o_Tx_byte, 8'h09);
    tx_finish();
    check("f1_frame_done", o_Frame_done, 1);
    check("f1_done_busy", o_Busy, 1);
    // A byte during DONE is an overrun, not a new length byte
    send_byte(8'h03);
    check("done_ovr_err", o_Err, 1);
    check("done_ovr_code", o_Err_code, 2'b11);
    check("done_ovr_idle", o_Busy, 0);
    check("done_pulse_end", o_Frame_done, 0);

    // Bad lengths 00 and 09
    send_byte(8'h00);
    check("len0_err", o_Err, 1);
    check("len0_code", o_Err_code, 2'b01);
    check("len0_busy", o_Busy, 0);
    step();
    check("len0_err_pulse", o_Err, 0);
    check("len0_code_hold", o_Err_code, 2'b01);
    send_byte(8'h09);
    check("len9_err", o_Err, 1);
    check("len9_code", o_Err_code, 2'b01);
    check("len9_busy", o_Busy, 0);

    // Timeout: 04,AA,BB then silence
    send_byte(8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TMO - 1) step();
    check("tmo_not_yet", o_Err, 0);
    check("tmo_still_busy", o_Busy, 1);
    step();
    check("tmo_err", o_Err, 1);
    check("tmo_code", o_Err_code, 2'b10);
    check("tmo_idle", o_Busy, 0);
    check("tmo_discard", o_Sort_data, 0);

    // Valid frame 02,30,10; the 30 arrives on the cycle the timeout would fire
    send_byte(8'h02);
    repeat (TMO - 1) step();
    send_byte(8'h30);
    check("tmo_edge_no_err", o_Err, 0);
    check("tmo_edge_busy", o_Busy, 1);
    send_byte(8'h10);
    check("f2_sort_start", o_Sort_start, 1);
    check("f2_sort_len", o_Sort_len, 2);
    check("f2_sort_data", o_Sort_data, 64'h0000_0000_0000_1030);
    step();
    // Overrun during SORT_WAIT
    send_byte(8'h7E);
    check("ovr_err", o_Err, 1);
    check("ovr_code", o_Err_code, 2'b11);
    check("ovr_busy", o_Busy, 1);
    check("ovr_data_kept", o_Sort_data, 64'h0000_0000_0000_1030);
    step();
    // Simultaneous sort done and overrun; upper sorter entries must be masked
    i_Rx_DV     = 1'b1;
    i_Rx_byte   = 8'h55;
    i_Sort_done = 1'b1;
    i_Sort_data = 64'hFFFF_FFFF_FFFF_3010;
    step();
    i_Rx_DV     = 1'b0;
    i_Sort_done = 1'b0;
    check("sim_tx_dv", o_Tx_DV, 1);
    check("sim_tx_byte", o_Tx_byte, 8'h10);
    check("sim_err", o_Err, 1);
    check("sim_code", o_Err_code, 2'b11);
    check("sim_masked_data", o_Sort_data, 64'h0000_0000_0000_3010);
    // Transmitter stays active for 100 cycles after the first done
    i_Tx_active = 1'b1;
    step();
    step();
    i_Tx_done = 1'b1;
    step();
    i_Tx_done = 1'b0;
    seen_dv = 1'b0;
    repeat (100) begin
      step();
      if (o_Tx_DV) seen_dv = 1'b1;
    end
    check("active_blocks_tx", seen_dv, 0);
    i_Tx_active = 1'b0;
    step();
    check("active_drop_dv", o_Tx_DV, 1);
    check("active_drop_byte", o_Tx_byte, 8'h30);
    tx_finish();
    check("f2_frame_done", o_Frame_done, 1);
    step();
    check("f2_idle", o_Busy, 0);

    // Reset during TX_WAIT of byte 2
    send_byte(8'h02);
    send_byte(8'h44);
    send_byte(8'h22);
    step();
    sort_done(64'h0000_0000_0000_4422);
    check("f3_tx0_byte", o_Tx_byte, 8'h22);
    tx_finish();
    step();
    check("f3_tx1_dv", o_Tx_DV, 1);
    check("f3_tx1_byte", o_Tx_byte, 8'h44);
    i_reset     = 1'b1;
    i_Tx_active = 1'b1;
    step();
    check_all_zero("midrst");
    i_reset     = 1'b0;
    i_Tx_active = 1'b0;
    i_Tx_done   = 1'b1;
    step();
    i_Tx_done   = 1'b0;
    check("midrst_no_frame_done", o_Frame_done, 0);
    check("midrst_idle", o_Busy, 0);

    // Fresh frame 01,5A with the transmitter busy at sort completion
    send_byte(8'h01);
    send_byte(8'h5A);
    check("f4_sort_start", o_Sort_start, 1);
    check("f4_sort_len", o_Sort_len, 1);
    check("f4_sort_data", o_Sort_data, 64'h0000_0000_0000_005A);
    step();
    i_Tx_active = 1'b1;
    sort_done(64'h0000_0000_0000_005A);
    check("f4_busy_tx_hold", o_Tx_DV, 0);
    step();
    i_Tx_active = 1'b0;
    step();
    check("f4_tx_dv", o_Tx_DV, 1);
    check("f4_tx_byte", o_Tx_byte, 8'h5A);
    tx_finish();
    check("f4_frame_done", o_Frame_done, 1);
    step();
    check("f4_idle", o_Busy, 0);
    check("f4_frame_done_pulse", o_Frame_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_sort_ctrl.md
# uart_sort_ctrl

Frame sequencer between the UART receiver, the bubble-sort engine and the UART transmitter. It collects a length-prefixed frame of bytes from the receiver's valid/byte outputs into an internal buffer and launches the sorter. When the sorter finishes, it streams the sorted bytes to the transmitter one byte at a time using the transmitter's active/done handshake. It also detects malformed frames, inter-byte timeouts and overrun bytes.

## Interface
- MAX_LEN, 8: maximum data bytes per frame; legal range 1..15.
- TIMEOUT_CLKS, 5700: idle clocks allowed between bytes inside a frame; 1..65535.
- i_clock  in  1  single system clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_Rx_DV  in  1  one-cycle byte-valid pulse from the UART receiver.
- i_Rx_byte  in  8  received byte; sampled only when i_Rx_DV=1.
- o_Sort_start  out  1  one-cycle pulse launching the sorter.
- o_Sort_len  out  4  number of valid entries (L) for the sorter.
- o_Sort_data  out  8*MAX_LEN  buffer contents; entry k is bits [8k+7:8k].
- i_Sort_done  in  1  one-cycle pulse from the sorter; result valid on the same cycle.
- i_Sort_data  in  8*MAX_LEN  sorted result, same packing as o_Sort_data.
- o_Tx_DV  out  1  one-cycle pulse requesting transmission of o_Tx_byte.
- o_Tx_byte  out  8  byte to transmit; held until the next o_Tx_DV.
- i_Tx_active  in  1  transmitter busy.
- i_Tx_done  in  1  one-cycle pulse when the transmitter finishes a byte.
- o_Busy  out  1  high in every state except IDLE.
- o_Frame_done  out  1  one-cycle pulse after the last sorted byte is sent.
- o_Err  out  1  one-cycle error pulse.
- o_Err_code  out  2  01 bad length, 10 timeout, 11 overrun; holds its last value.

## Operation
- States: IDLE, RX_DATA, SORT_START, SORT_WAIT, TX_SEND, TX_WAIT, DONE.
- IDLE: the first i_Rx_DV byte is the length L.
  - L in 1..MAX_LEN: store L, clear the buffer to 0, clear the byte index and timeout counter, go to RX_DATA.
  - Otherwise (L=0 or L>MAX_LEN): o_Err=1 with code 01, stay in IDLE.
- RX_DATA: on each i_Rx_DV, write buf[idx]=i_Rx_byte, increment idx, clear the timeout counter. Go to SORT_START when the L-th byte is written.
  - With no byte, the counter increments.
  - When the counter reaches TIMEOUT_CLKS-1: o_Err with code 10, go to IDLE, discard partial data.
- SORT_START: o_Sort_start=1 for one cycle, go to SORT_WAIT.
  - o_Sort_len=L and o_Sort_data are stable from this cycle until i_Sort_done.
- SORT_WAIT: on i_Sort_done, load buf from i_Sort_data, clear tx_idx, go to TX_SEND. No timeout in this state.
- TX_SEND: when i_Tx_active=0, pulse o_Tx_DV with o_Tx_byte=buf[tx_idx] and go to TX_WAIT; otherwise wait.
- TX_WAIT: on i_Tx_done, go to DONE if tx_idx=L-1; otherwise increment tx_idx and return to TX_SEND.
- DONE: o_Frame_done=1 for one cycle, go to IDLE.
- Overrun: an i_Rx_DV in SORT_START through DONE is dropped and raises o_Err with code 11; the state is unaffected.
- Only buffer entries 0..L-1 are transmitted; entries >=L stay 0 in o_Sort_data.

## Timing
- Reset values:
  - state IDLE, buffer all 0, L=0, all counters 0.
  - o_Sort_start, o_Tx_DV, o_Frame_done, o_Err, o_Busy = 0.
  - o_Sort_len=0, o_Tx_byte=0, o_Err_code=00.
- Reset mid-frame aborts the frame; no pulse is emitted on the cycle after reset.
- Last data byte's i_Rx_DV at cycle t -> o_Sort_start at t+1.
- i_Sort_done at t -> o_Tx_DV at t+1 if i_Tx_active=0.
- i_Tx_done at t -> next o_Tx_DV at t+2 at the earliest (TX_WAIT→TX_SEND at t+1, pulse registered at t+2).
- All outputs are registered; pulses last exactly one cycle.
- i_Rx_DV on the same cycle the timeout would fire: the byte is accepted and there is no error.
- i_Rx_DV in DONE: counted as an overrun, not treated as a new length byte.
- Simultaneous i_Sort_done and overrun byte: the result is accepted and o_Err/11 is raised.

## Test plan
- Frame 03,05,01,09; sorter model returns 01,05,09; transmitter model idles -> one o_Sort_start with len 3; o_Tx_DV bytes 01,05,09 in order; o_Frame_done after the third i_Tx_done.
- Length byte 00, then length byte 09 with MAX_LEN=8 -> two o_Err pulses with code 01; o_Busy stays 0.
- Frame 04,AA,BB, then no bytes for TIMEOUT_CLKS cycles -> o_Err with code 10; IDLE; a following valid frame processes normally.
- Byte 7E injected during SORT_WAIT -> o_Err with code 11; the sorted output is unchanged.
- i_Tx_active held high for 100 cycles in TX_SEND -> no o_Tx_DV until it drops; then exactly one pulse.
- i_reset asserted during TX_WAIT of byte 2 -> all outputs 0 the next cycle; no o_Frame_done; a fresh frame completes.
